// File: rtl/pulse_train_generator_if.sv
// Trigger/configuration inputs and pulse-train status outputs of pulse_train_generator.
// The master drives the i_* side; the generator is the slave.
interface pulse_train_generator_if #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned BURST_W = 4
);
  logic               i_on;
  logic               i_mode;
  logic               i_abort;
  logic [CNT_W-1:0]   i_delay;
  logic [CNT_W-1:0]   i_high;
  logic [CNT_W-1:0]   i_low;
  logic [BURST_W-1:0] i_count;
  logic               o_signal;
  logic               o_busy;
  logic               o_done;
  logic [BURST_W-1:0] o_pulses;

  modport master (
    output i_on, i_mode, i_abort, i_delay, i_high, i_low, i_count,
    input  o_signal, o_busy, o_done, o_pulses
  );

  modport slave (
    input  i_on, i_mode, i_abort, i_delay, i_high, i_low, i_count,
    output o_signal, o_busy, o_done, o_pulses
  );
endinterface

// File: rtl/pulse_train_generator.sv
// Edge-triggered burst pulse generator: delay, then high/low pulses, counted or continuous.
// Supports retriggerable bursts, synchronous abort and asynchronous active-high reset.
module pulse_train_generator #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned BURST_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pulse_train_generator_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HIGH, S_LOW} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_on_q;
  logic [CNT_W-1:0]   r_high;
  logic [CNT_W-1:0]   r_low;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BURST_W-1:0] r_count;
  logic [BURST_W-1:0] r_pulses;
  logic [BURST_W-1:0] w_pulses_nxt;
  logic               r_signal;
  logic               r_busy;
  logic               r_done;
  logic               w_trig;
  logic               w_latch;
  logic               w_done_nxt;
  logic [CNT_W-1:0]   w_in_high;
  logic [CNT_W-1:0]   w_sh_high;
  logic [CNT_W-1:0]   w_sh_low;

  assign w_trig    = bus.i_on & ~r_on_q;
  assign w_in_high = (bus.i_high == '0) ? CNT_W'(1) : bus.i_high;
  assign w_sh_high = (r_high == '0) ? CNT_W'(1) : r_high;
  assign w_sh_low  = (r_low == '0) ? CNT_W'(1) : r_low;

  // Next-state logic; the DELAY counter is loaded with the raw delay and exits at zero.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pulses_nxt = r_pulses;
    w_done_nxt   = 1'b0;
    w_latch      = 1'b0;

    case (r_state)
      S_DELAY: begin
        if (r_cnt == '0) begin
          w_state_nxt  = S_HIGH;
          w_cnt_nxt    = w_sh_high;
          w_pulses_nxt = r_pulses + BURST_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (r_cnt > CNT_W'(1)) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if ((r_count != '0) && (r_pulses == r_count)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = w_sh_low;
        end
      end
      S_LOW: begin
        if (r_cnt > CNT_W'(1)) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if ((r_count == '0) && !bus.i_on) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt  = S_HIGH;
          w_cnt_nxt    = w_sh_high;
          w_pulses_nxt = r_pulses + BURST_W'(1);
        end
      end
      default: ;
    endcase

    // A completing counted burst wins over a retrigger in the same cycle.
    if (w_trig && ((r_state == S_IDLE) || (bus.i_mode && !w_done_nxt))) begin
      w_latch      = 1'b1;
      w_pulses_nxt = '0;
      if ((r_state == S_IDLE) || (bus.i_delay != '0)) begin
        w_state_nxt = S_DELAY;
        w_cnt_nxt   = bus.i_delay;
      end else begin
        w_state_nxt  = S_HIGH;
        w_cnt_nxt    = w_in_high;
        w_pulses_nxt = BURST_W'(1);
      end
    end

    if (bus.i_abort) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = r_cnt;
      w_pulses_nxt = r_pulses;
      w_done_nxt   = 1'b0;
      w_latch      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, shadow configuration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_on_q   <= 1'b0;
      r_cnt    <= '0;
      r_pulses <= '0;
      r_high   <= '0;
      r_low    <= '0;
      r_count  <= '0;
      r_signal <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_on_q   <= bus.i_on;
      r_cnt    <= w_cnt_nxt;
      r_pulses <= w_pulses_nxt;
      r_signal <= (w_state_nxt == S_HIGH);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= w_done_nxt;
      if (w_latch) begin
        r_high  <= bus.i_high;
        r_low   <= bus.i_low;
        r_count <= bus.i_count;
      end
    end
  end

  assign bus.o_signal = r_signal;
  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_pulses = r_pulses;

endmodule
